flag_click_decoder: RTL

Converts a right-button mouse click into a one-cycle flag-toggle request with 1-based tile indices. Sits directly upstream of the flag array generator and drives its `mark_flag`, `flag_ind_x` and `flag_ind_y` inputs. Pixel-to-tile conversion uses a per-level tile size and iterative subtraction, with no divider. Clicks outside the active board, or made while the game is inactive, are discarded.

---
 rtl/flag_click_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/flag_click_decoder.sv
// Turns a right-button click on the board into a one-cycle flag toggle with 1-based tile indices.
// Optional post-click lockout: define FLAG_CLICK_HOLDOFF_EN.
module flag_click_decoder #(
  parameter int unsigned BOARD_XPOS     = 192,
  parameter int unsigned BOARD_YPOS     = 64,
  parameter int unsigned SIZE_EASY      = 64,
  parameter int unsigned SIZE_MEDIUM    = 48,
  parameter int unsigned SIZE_HARD      = 32,
  parameter int unsigned HOLDOFF_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  level,
  input  logic        game_active,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        right,
  output logic        mark_flag,
  output logic [4:0]  flag_ind_x,
  output logic [4:0]  flag_ind_y,
  output logic        busy
);

  localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [12:0] X0 = 13'(BOARD_XPOS);
  localparam logic [12:0] Y0 = 13'(BOARD_YPOS);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
`ifdef FLAG_CLICK_HOLDOFF_EN
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
`endif

  typedef enum logic [2:0] {IDLE, CALC, CHECK, DONE, HOLD} state_t;

  state_t state, state_n;
  logic              right_d;
  logic [12:0]       ox, oy, ox_n, oy_n;
  logic [4:0]        ix, iy, ix_n, iy_n;
  logic [4:0]        dim, dim_n;
  logic [12:0]       size, size_n;
  logic              mark_n;
  logic [4:0]        fx_n, fy_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;

  logic        click;
  logic [4:0]  lvl_dim;
  logic [12:0] lvl_size;
  logic [12:0] dx, dy;
  logic        step_x, step_y;

  // Bit 12 of the offsets is the borrow: set when the click lies left of or above the board.
  assign click  = right & ~right_d & game_active;
  assign dx     = {1'b0, xpos} - X0;
  assign dy     = {1'b0, ypos} - Y0;
  assign step_x = (ox >= size) && (ix < dim);
  assign step_y = (oy >= size) && (iy < dim);
  assign busy   = (state != IDLE);

  always_comb begin
    lvl_dim  = 5'd8;
    lvl_size = 13'(SIZE_EASY);
    case (level)
      2'd3: begin
        lvl_dim  = 5'd16;
        lvl_size = 13'(SIZE_HARD);
      end
      2'd2: begin
        lvl_dim  = 5'd10;
        lvl_size = 13'(SIZE_MEDIUM);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    ox_n    = ox;
    oy_n    = oy;
    ix_n    = ix;
    iy_n    = iy;
    dim_n   = dim;
    size_n  = size;
    mark_n  = 1'b0;
    fx_n    = flag_ind_x;
    fy_n    = flag_ind_y;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        if (click) begin
          dim_n  = lvl_dim;
          size_n = lvl_size;
          ox_n   = dx;
          oy_n   = dy;
          ix_n   = 5'd0;
          iy_n   = 5'd0;
          if (!dx[12] && !dy[12]) state_n = CALC;
        end
      end
      CALC: begin
        // Both axes divide by repeated subtraction in parallel; the counters saturate at dim.
        if (step_x) begin
          ox_n = ox - size;
          ix_n = ix + 5'd1;
        end
        if (step_y) begin
          oy_n = oy - size;
          iy_n = iy + 5'd1;
        end
        if (!step_x && !step_y) state_n = CHECK;
      end
      CHECK: begin
        if ((ix < dim) && (iy < dim)) begin
          fx_n    = ix + 5'd1;
          fy_n    = iy + 5'd1;
          mark_n  = 1'b1;
          state_n = DONE;
        end else begin
          state_n = IDLE;
        end
      end
      DONE: begin
`ifdef FLAG_CLICK_HOLDOFF_EN
        hold_n  = HOLD_LOAD;
        state_n = HOLD;
`else
        state_n = IDLE;
`endif
      end
      HOLD: begin
        if (hold_cnt == '0) state_n = IDLE;
        else                hold_n  = hold_cnt - HOLD_ONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      right_d    <= 1'b0;
      ox         <= '0;
      oy         <= '0;
      ix         <= '0;
      iy         <= '0;
      dim        <= '0;
      size       <= '0;
      mark_flag  <= 1'b0;
      flag_ind_x <= '0;
      flag_ind_y <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      right_d    <= right;
      ox         <= ox_n;
      oy         <= oy_n;
      ix         <= ix_n;
      iy         <= iy_n;
      dim        <= dim_n;
      size       <= size_n;
      mark_flag  <= mark_n;
      flag_ind_x <= fx_n;
      flag_ind_y <= fy_n;
      hold_cnt   <= hold_n;
    end
  end

endmodule
